prog_delay_bank: RTL and testbench

// - Per-channel programmable delay line bank with a runtime config port, optional pulse stretching and settle tracking.
// - Successor to the fixed-tap channel delayer; sits between input synchronisers and the coincidence logic.
// - Aligns NCHAN detector channels in time, then shapes each into a level or a fixed-width window pulse.

---
 rtl/prog_delay_pkg.sv | 22 ++
 rtl/delay_channel.sv | 104 ++++++++++
 rtl/prog_delay_bank.sv | 62 ++++++
 tb/tb_prog_delay_bank.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_delay_pkg.sv
// Shared types and sizing for the programmable per-channel delay bank.
package prog_delay_pkg;

  localparam int unsigned NCHAN_DEF = 4;
  localparam int unsigned NBITS_DEF = 4;
  localparam int unsigned WBITS_DEF = 3;
  localparam int unsigned DEPTH     = 2 ** NBITS_DEF;

  typedef logic [NBITS_DEF-1:0] dly_t;
  typedef logic [WBITS_DEF-1:0] wid_t;

  typedef enum logic {
    MODE_LEVEL = 1'b0,
    MODE_PULSE = 1'b1
  } mode_e;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SETTLE = 1'b1
  } chan_state_e;

endpackage

// File: rtl/delay_channel.sv
// One channel: delay chain, tap select, rising-edge stretcher and the RUN/SETTLE
// tracker that blanks the output while the chain refills after a reconfig.
module delay_channel
  import prog_delay_pkg::*;
#(
  parameter int unsigned NBITS = NBITS_DEF,
  parameter int unsigned WBITS = WBITS_DEF
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             din,
  input  logic             wr,
  input  logic [NBITS-1:0] dly,
  input  logic [WBITS-1:0] wid,
  input  logic             mode,
  output logic             dout,
  output logic             settling
);

  localparam int unsigned CDEPTH = 2 ** NBITS;
  localparam int unsigned SRLEN  = CDEPTH - 1;

  logic [SRLEN-1:0]  sr;
  logic [NBITS-1:0]  dly_q;
  logic [WBITS-1:0]  wid_q;
  mode_e             mode_q;
  chan_state_e       state_q;
  logic [NBITS-1:0]  scnt_q;
  logic [WBITS-1:0]  pcnt_q;
  logic              tap_q;

  logic [CDEPTH-1:0] taps_c;
  logic              tap_c;
  logic              rise_c;
  logic              settle_next_c;

  // Index 0 is the undelayed input, index k is sr[k-1].
  always_comb begin
    taps_c        = {sr, din};
    tap_c         = taps_c[dly_q];
    rise_c        = tap_c & ~tap_q;
    settle_next_c = (state_q == ST_SETTLE) && (scnt_q != NBITS'(CDEPTH - 1));
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      sr       <= '0;
      dly_q    <= '0;
      wid_q    <= '0;
      mode_q   <= MODE_LEVEL;
      state_q  <= ST_RUN;
      scnt_q   <= '0;
      pcnt_q   <= '0;
      tap_q    <= 1'b0;
      dout     <= 1'b0;
      settling <= 1'b0;
    end else if (wr) begin
      dly_q    <= dly;
      wid_q    <= wid;
      mode_q   <= mode_e'(mode);
      sr       <= '0;
      tap_q    <= 1'b0;
      pcnt_q   <= '0;
      dout     <= 1'b0;
      state_q  <= ST_SETTLE;
      scnt_q   <= '0;
      settling <= 1'b1;
    end else begin
      // Chain keeps shifting during settle so the history is valid on exit.
      sr    <= {sr[SRLEN-2:0], din};
      tap_q <= tap_c;

      case (state_q)
        ST_SETTLE: begin
          if (scnt_q == NBITS'(CDEPTH - 1)) begin
            state_q  <= ST_RUN;
            settling <= 1'b0;
          end else begin
            scnt_q <= scnt_q + NBITS'(1);
          end
        end
        default: begin
          state_q <= ST_RUN;
        end
      endcase

      if (settle_next_c) begin
        dout   <= 1'b0;
        pcnt_q <= '0;
      end else if (mode_q == MODE_LEVEL) begin
        dout <= tap_c;
      end else if (rise_c) begin
        pcnt_q <= wid_q;
        dout   <= 1'b1;
      end else if (pcnt_q != '0) begin
        pcnt_q <= pcnt_q - WBITS'(1);
        dout   <= 1'b1;
      end else begin
        dout <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/prog_delay_bank.sv
// Bank of independently programmable delay/stretch channels behind a single
// config write port; flags writes aimed at a non-existent channel.
module prog_delay_bank
  import prog_delay_pkg::*;
#(
  parameter int unsigned NCHAN  = NCHAN_DEF,
  parameter int unsigned NBITS  = NBITS_DEF,
  parameter int unsigned WBITS  = WBITS_DEF,
  // One spare code point so an out-of-range index can be presented and flagged.
  parameter int unsigned CHBITS = $clog2(NCHAN + 1)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [NCHAN-1:0]  Channels,
  input  logic              CfgWe,
  input  logic [CHBITS-1:0] CfgChan,
  input  logic [NBITS-1:0]  CfgDelay,
  input  logic [WBITS-1:0]  CfgWidth,
  input  logic              CfgMode,
  output logic              CfgErr,
  output logic [NCHAN-1:0]  DlayChann,
  output logic [NCHAN-1:0]  Settling
);

  logic             cfg_valid_c;
  logic [NCHAN-1:0] wr_c;

  // Decode the config port into one write strobe per channel.
  always_comb begin
    wr_c        = '0;
    cfg_valid_c = CfgWe && (CfgChan < CHBITS'(NCHAN));
    for (int unsigned i = 0; i < NCHAN; i++) begin
      wr_c[i] = cfg_valid_c && (CfgChan == CHBITS'(i));
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      CfgErr <= 1'b0;
    end else begin
      CfgErr <= CfgWe && !cfg_valid_c;
    end
  end

  for (genvar g = 0; g < NCHAN; g++) begin : g_chan
    delay_channel #(
      .NBITS (NBITS),
      .WBITS (WBITS)
    ) u_chan (
      .Clk      (Clk),
      .Rst      (Rst),
      .din      (Channels[g]),
      .wr       (wr_c[g]),
      .dly      (CfgDelay),
      .wid      (CfgWidth),
      .mode     (CfgMode),
      .dout     (DlayChann[g]),
      .settling (Settling[g])
    );
  end

endmodule

// File: tb/tb_prog_delay_bank.sv
// Randomised and directed bench for prog_delay_bank against an edge-indexed
// history model of the delay, settle and stretch rules.
module tb_prog_delay_bank;

  localparam int NC   = 4;
  localparam int DP   = 16;
  localparam int MAXE = 8192;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [3:0] Channels;
  logic       CfgWe;
  logic [2:0] CfgChan;
  logic [3:0] CfgDelay;
  logic [2:0] CfgWidth;
  logic       CfgMode;
  logic       CfgErr;
  logic [3:0] DlayChann;
  logic [3:0] Settling;

  prog_delay_bank dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Channels  (Channels),
    .CfgWe     (CfgWe),
    .CfgChan   (CfgChan),
    .CfgDelay  (CfgDelay),
    .CfgWidth  (CfgWidth),
    .CfgMode   (CfgMode),
    .CfgErr    (CfgErr),
    .DlayChann (DlayChann),
    .Settling  (Settling)
  );

  always #5 Clk = ~Clk;

  int tests  = 0;
  int failed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: per-edge input history, plus for each channel the edge of its last
  // clear (reset or write) and the first edge on which its output is live.
  bit in_hist [NC][MAXE];
  int m_d    [NC];
  int m_w    [NC];
  int m_mode [NC];
  int m_clr  [NC];
  int m_act  [NC];
  bit m_wr   [NC];
  bit m_err;
  bit model_ok = 1'b0;
  int ecount   = 0;

  always @(posedge Clk) begin
    int n;
    n = ecount;
    if (n < MAXE) begin
      for (int c = 0; c < NC; c++) in_hist[c][n] = Channels[c];
    end
    if (Rst) begin
      for (int c = 0; c < NC; c++) begin
        m_d[c] = 0; m_w[c] = 0; m_mode[c] = 0;
        m_clr[c] = n; m_act[c] = n + 1; m_wr[c] = 1'b0;
      end
      m_err    = 1'b0;
      model_ok = 1'b1;
    end else begin
      m_err = CfgWe && (int'(CfgChan) >= NC);
      if (CfgWe && (int'(CfgChan) < NC)) begin
        m_d[CfgChan]    = int'(CfgDelay);
        m_w[CfgChan]    = int'(CfgWidth);
        m_mode[CfgChan] = int'(CfgMode);
        m_clr[CfgChan]  = n;
        m_act[CfgChan]  = n + DP;
        m_wr[CfgChan]   = 1'b1;
      end
    end
    ecount = n + 1;
  end

  // Delayed tap at edge m: the input sampled D edges earlier, if it arrived after the clear.
  function automatic bit m_tap(input int c, input int m);
    int src;
    src = m - m_d[c];
    if (src <= m_clr[c] || src >= MAXE) return 1'b0;
    return in_hist[c][src];
  endfunction

  function automatic bit m_out(input int c, input int n);
    int lo;
    if (n < m_act[c]) return 1'b0;
    if (m_mode[c] == 0) return m_tap(c, n);
    lo = n - m_w[c];
    if (lo < m_act[c]) lo = m_act[c];
    for (int m = lo; m <= n; m++) begin
      if (m_tap(c, m) && !m_tap(c, m - 1)) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge Clk) begin
    logic [3:0] e_d, e_s;
    int n;
    if (model_ok && ecount > 0 && ecount < MAXE) begin
      n = ecount - 1;
      for (int c = 0; c < NC; c++) begin
        e_d[c] = m_out(c, n);
        e_s[c] = m_wr[c] && (n < m_act[c]);
      end
      chk("model_dlay", 32'(DlayChann), 32'(e_d));
      chk("model_settling", 32'(Settling), 32'(e_s));
      chk("model_cfgerr", 32'(CfgErr), 32'(m_err));
    end
  end

  task automatic cyc();
    @(negedge Clk);
  endtask

  task automatic wcfg(input int ch, input int d, input int w, input int md);
    CfgWe    = 1'b1;
    CfgChan  = 3'(ch);
    CfgDelay = 4'(d);
    CfgWidth = 3'(w);
    CfgMode  = 1'(md);
    cyc();
    CfgWe = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    Rst = 1'b1; Channels = '0; CfgWe = 1'b0; CfgChan = '0;
    CfgDelay = '0; CfgWidth = '0; CfgMode = 1'b0;
    repeat (3) cyc();
    chk("reset_dlay", 32'(DlayChann), 32'h0);
    chk("reset_settling", 32'(Settling), 32'h0);
    chk("reset_cfgerr", 32'(CfgErr), 32'h0);
    Rst = 1'b0;
    cyc();

    // D=0 level: one-cycle latency, single-cycle output.
    Channels = 4'b0001; cyc(); Channels = '0;
    chk("d0_pulse_hi", 32'(DlayChann), 32'h1);
    cyc();
    chk("d0_pulse_lo", 32'(DlayChann), 32'h0);

    // ch2 D=15: settle for 16 cycles, then 16-cycle latency.
    wcfg(2, 15, 0, 0);
    chk("ch2_settle_start", 32'(Settling), 32'b0100);
    for (int k = 1; k <= 15; k++) begin
      cyc();
      chk("ch2_settle_hold", 32'(Settling[2]), 32'h1);
    end
    cyc();
    chk("ch2_settle_end", 32'(Settling), 32'h0);
    Channels = 4'b0100; cyc(); Channels = '0;
    for (int k = 1; k <= 16; k++) begin
      cyc();
      chk("ch2_d15_out", 32'(DlayChann[2]), 32'(k == 15));
    end

    // ch1 pulse D=3 W=4: five-cycle pulse.
    wcfg(1, 3, 4, 1);
    repeat (16) cyc();
    chk("ch1_settled", 32'(Settling), 32'h0);
    Channels = 4'b0010; cyc(); Channels = '0;
    for (int k = 1; k <= 9; k++) begin
      cyc();
      chk("ch1_pulse", 32'(DlayChann[1]), 32'(k >= 3 && k <= 7));
    end

    // Retrigger two cycles later: continuous high, extended by the second edge.
    Channels = 4'b0010; cyc(); Channels = '0; cyc();
    Channels = 4'b0010; cyc(); Channels = '0;
    for (int k = 3; k <= 12; k++) begin
      cyc();
      chk("ch1_retrig", 32'(DlayChann[1]), 32'(k >= 3 && k <= 9));
    end

    // Rewrite ch0 mid-settle while ch3 carries random traffic.
    wcfg(0, 2, 0, 0);
    for (int k = 1; k <= 7; k++) begin
      Channels = {1'($urandom_range(0, 1)), 3'b000}; cyc();
    end
    Channels = {1'($urandom_range(0, 1)), 3'b000};
    wcfg(0, 2, 0, 0);
    chk("ch0_rewrite", 32'(Settling[0]), 32'h1);
    for (int k = 1; k <= 15; k++) begin
      Channels = {1'($urandom_range(0, 1)), 3'b000}; cyc();
      chk("ch0_resettle", 32'(Settling[0]), 32'h1);
    end
    Channels = '0; cyc();
    chk("ch0_resettle_end", 32'(Settling[0]), 32'h0);

    // Out-of-range index: error pulse, nothing else moves.
    wcfg(4, 7, 7, 1);
    chk("cfgerr_hi", 32'(CfgErr), 32'h1);
    chk("cfgerr_no_settle", 32'(Settling), 32'h0);
    cyc();
    chk("cfgerr_lo", 32'(CfgErr), 32'h0);

    // Reset during settle.
    wcfg(1, 5, 2, 1);
    repeat (4) cyc();
    chk("pre_rst_settling", 32'(Settling), 32'b0010);
    Rst = 1'b1; Channels = 4'b1111; cyc();
    chk("rst_dlay", 32'(DlayChann), 32'h0);
    chk("rst_settling", 32'(Settling), 32'h0);
    chk("rst_cfgerr", 32'(CfgErr), 32'h0);
    Rst = 1'b0; Channels = '0; cyc();

    // Randomised traffic, configuration and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NC; c++) Channels[c] = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 39) == 0) begin
        CfgWe    = 1'b1;
        CfgChan  = 3'($urandom_range(0, 5));
        CfgDelay = 4'($urandom);
        CfgWidth = 3'($urandom);
        CfgMode  = 1'($urandom);
      end else begin
        CfgWe = 1'b0;
      end
      Rst = ($urandom_range(0, 499) == 0);
      cyc();
    end
    Rst = 1'b0; CfgWe = 1'b0; Channels = '0;
    repeat (2) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
